stopwatch_ctrl: RTL and testbench

Button-level sequencer for the M.S1S0.D enhanced stopwatch datapath. Debounces start/stop, lap and clear pushbuttons plus the direction switch, and drives the counter's `go`, `up` and clear inputs through a small FSM. It also owns the 6-digit display path, freezing a lap snapshot while the counter keeps running. It sits between the board I/O and the stopwatch counter, ahead of the seven-segment multiplexer.

---
 rtl/stopwatch_pkg.sv | 44 ++++
 rtl/stopwatch_ctrl_if.sv | 45 ++++
 rtl/stopwatch_ctrl_debounce.sv | 75 +++++++
 rtl/stopwatch_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch button sequencer:
//   - state_t      : FSM state encoding (also driven out on the debug port)
//   - DIGIT_W      : width of one {dp, value} display digit
//   - DP_BIT       : index of the decimal-point bit inside a digit
//   - DIGIT_*      : fixed digit codes (blank, "1" direction marker, "A" lap marker)
//   - LIM_UP/DN    : packed {M, S1, S0, D} bounds for limit detection
//   - at_limit()   : compares packed digit values against the bound for a direction
// -----------------------------------------------------------------------------
package stopwatch_pkg;

   localparam int DIGIT_W = 5;
   localparam int DP_BIT  = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_PAUSE = 3'd2,
      ST_LAP   = 3'd3,
      ST_LIMIT = 3'd4,
      ST_CLR   = 3'd5
   } state_t;

   localparam logic [DIGIT_W-1:0] DIGIT_BLANK = 5'b0_0000;
   localparam logic [DIGIT_W-1:0] DIGIT_ONE   = 5'b0_0001;
   localparam logic [DIGIT_W-1:0] DIGIT_A     = 5'b0_1010;

   // Digit values packed as {M, S1, S0, D}, 4 bits each.
   localparam logic [15:0] LIM_UP = {4'd9, 4'd5, 4'd9, 4'd9};
   localparam logic [15:0] LIM_DN = {4'd0, 4'd0, 4'd0, 4'd0};

   // True when the packed digit values sit on the bound of the given direction.
   function automatic logic at_limit(input logic [15:0] digits, input logic dir_up);
      logic hit;
      if (dir_up) begin
         hit = (digits == LIM_UP);
      end else begin
         hit = (digits == LIM_DN);
      end
      return hit;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl_if
// Bundle between the sequencer, the stopwatch counter and the display path.
//   cnt0..cnt3  : counter digits D, S0, S1, M in {dp, value} format
//   go, up      : counter enable and direction
//   clr_n       : active-low counter clear pulse
//   disp0..disp5: display digits in {dp, value} format
//   state       : FSM state code for debug / LEDs
// Modports:
//   master : the sequencer (drives control + display, reads counter digits)
//   slave  : the counter / display side
// -----------------------------------------------------------------------------
interface stopwatch_ctrl_if;
   import stopwatch_pkg::*;

   logic [DIGIT_W-1:0] cnt0;
   logic [DIGIT_W-1:0] cnt1;
   logic [DIGIT_W-1:0] cnt2;
   logic [DIGIT_W-1:0] cnt3;
   logic               go;
   logic               up;
   logic               clr_n;
   logic [DIGIT_W-1:0] disp0;
   logic [DIGIT_W-1:0] disp1;
   logic [DIGIT_W-1:0] disp2;
   logic [DIGIT_W-1:0] disp3;
   logic [DIGIT_W-1:0] disp4;
   logic [DIGIT_W-1:0] disp5;
   logic [2:0]         state;

   modport master (
      input  cnt0, cnt1, cnt2, cnt3,
      output go, up, clr_n,
      output disp0, disp1, disp2, disp3, disp4, disp5,
      output state
   );

   modport slave (
      output cnt0, cnt1, cnt2, cnt3,
      input  go, up, clr_n,
      input  disp0, disp1, disp2, disp3, disp4, disp5,
      input  state
   );

endinterface

// File: rtl/stopwatch_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// debounce
// Two-flop synchronizer, stability-count debouncer and rising-edge pulse for
// one raw board input.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : raw asynchronous input
//   level      : debounced level (changes after DB_CYCLES stable cycles)
//   rise       : registered 1-cycle pulse on a rising edge of level
// -----------------------------------------------------------------------------
module debounce #(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int CNT_W = $clog2(DB_CYCLES + 1);

   logic             sync1_r;
   logic             sync2_r;
   logic             level_r;
   logic             level_d_r;
   logic             rise_r;
   logic [CNT_W-1:0] stab_cnt_r;

   // Two-flop synchronizer for the asynchronous raw input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= raw;
         sync2_r <= sync1_r;
      end
   end

   // Stability counter: level follows the synchronized input only after it
   // has disagreed for DB_CYCLES consecutive cycles; any agreement restarts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stab_cnt_r <= {CNT_W{1'b0}};
         level_r    <= 1'b0;
      end else if (sync2_r != level_r) begin
         if (stab_cnt_r == CNT_W'(DB_CYCLES - 1)) begin
            stab_cnt_r <= {CNT_W{1'b0}};
            level_r    <= sync2_r;
         end else begin
            stab_cnt_r <= stab_cnt_r + CNT_W'(1);
            level_r    <= level_r;
         end
      end else begin
         stab_cnt_r <= {CNT_W{1'b0}};
         level_r    <= level_r;
      end
   end

   // Registered rising-edge detector on the debounced level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_d_r <= 1'b0;
         rise_r    <= 1'b0;
      end else begin
         level_d_r <= level_r;
         rise_r    <= level_r & ~level_d_r;
      end
   end

   assign level = level_r;
   assign rise  = rise_r;

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Button-level sequencer for the M.S1S0.D stopwatch: debounces the start/stop,
// lap and clear buttons plus the direction switch, runs the control FSM that
// drives the counter's go/up/clr_n, and muxes the 6-digit display including a
// frozen lap snapshot.
// Ports:
//   clk, rst_n                 : 50 MHz clock, asynchronous active-low reset
//   btn_ss, btn_lap, btn_clr   : raw active-high pushbuttons
//   sw_up                      : raw direction switch (1 = count up)
//   bus (stopwatch_ctrl_if.master):
//      cnt0..cnt3 in, go/up/clr_n out, disp0..disp5 out, state out
// -----------------------------------------------------------------------------
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int DB_CYCLES  = 1_000_000,
   parameter int CLR_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_ss,
   input  logic             btn_lap,
   input  logic             btn_clr,
   input  logic             sw_up,
   stopwatch_ctrl_if.master bus
);

   localparam int CLR_W = $clog2(CLR_CYCLES + 1);

   // Debounced inputs
   logic ss_lvl_s;
   logic lap_lvl_s;
   logic clr_lvl_s;
   logic ss_p_s;
   logic lap_p_s;
   logic clr_p_s;
   logic dir_s;
   logic dir_rise_unused_s;

   // FSM and datapath
   state_t                    state_r;
   state_t                    state_s;
   logic                      go_r;
   logic                      go_s;
   logic                      up_r;
   logic                      up_s;
   logic                      clr_n_r;
   logic [CLR_W-1:0]          clr_cnt_r;
   logic                      clr_done_s;
   logic                      enter_clr_s;
   logic                      enter_run_s;
   logic                      first_run_r;
   logic                      lap_en_s;
   logic [3:0][DIGIT_W-1:0]   lap_r;
   logic [15:0]               cnt_val_s;
   logic                      at_lim_s;
   logic                      lim_eff_s;

   debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
      .clk(clk), .rst_n(rst_n), .raw(btn_ss), .level(ss_lvl_s), .rise(ss_p_s)
   );

   debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
      .clk(clk), .rst_n(rst_n), .raw(btn_lap), .level(lap_lvl_s), .rise(lap_p_s)
   );

   debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
      .clk(clk), .rst_n(rst_n), .raw(btn_clr), .level(clr_lvl_s), .rise(clr_p_s)
   );

   debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
      .clk(clk), .rst_n(rst_n), .raw(sw_up), .level(dir_s), .rise(dir_rise_unused_s)
   );

   // Limit detection on digit values only; dp bits do not take part.
   always_comb begin
      cnt_val_s = {bus.cnt3[DP_BIT-1:0], bus.cnt2[DP_BIT-1:0],
                   bus.cnt1[DP_BIT-1:0], bus.cnt0[DP_BIT-1:0]};
      at_lim_s  = at_limit(cnt_val_s, up_r);
      // The first cycle in RUN ignores the limit so a resume from an
      // equal-but-opposite bound is not immediately bounced back.
      lim_eff_s = at_lim_s & ~first_run_r;
   end

   assign clr_done_s = (clr_cnt_r == CLR_W'(CLR_CYCLES - 1));

   // Next-state, direction latch and lap-capture decode.
   always_comb begin
      state_s  = state_r;
      up_s     = up_r;
      lap_en_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            up_s = dir_s;
            if (ss_p_s && !at_lim_s) begin
               state_s = ST_RUN;
            end else if (clr_p_s) begin
               state_s = ST_CLR;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (lim_eff_s) begin
               state_s = ST_LIMIT;
            end else if (ss_p_s) begin
               state_s = ST_PAUSE;
            end else if (lap_p_s) begin
               state_s  = ST_LAP;
               lap_en_s = 1'b1;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_LAP: begin
            if (lim_eff_s) begin
               state_s = ST_LIMIT;
            end else if (ss_p_s) begin
               state_s = ST_PAUSE;
            end else if (lap_p_s) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_LAP;
            end
         end
         ST_PAUSE: begin
            up_s = dir_s;
            if (ss_p_s && !at_lim_s) begin
               state_s = ST_RUN;
            end else if (clr_p_s) begin
               state_s = ST_CLR;
            end else begin
               state_s = ST_PAUSE;
            end
         end
         ST_LIMIT: begin
            // Direction is re-latched only by start/stop; restart is allowed
            // only when the new direction leads away from the bound.
            if (ss_p_s) begin
               up_s = dir_s;
            end else begin
               up_s = up_r;
            end
            if (ss_p_s && (dir_s != up_r)) begin
               state_s = ST_RUN;
            end else if (clr_p_s) begin
               state_s = ST_CLR;
            end else begin
               state_s = ST_LIMIT;
            end
         end
         ST_CLR: begin
            if (clr_done_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_CLR;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      go_s        = (state_s == ST_RUN) || (state_s == ST_LAP);
      enter_clr_s = (state_s == ST_CLR) && (state_r != ST_CLR);
      enter_run_s = (state_s == ST_RUN) && (state_r != ST_RUN);
   end

   // State, counter control and hysteresis registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         go_r        <= 1'b0;
         up_r        <= 1'b1;
         first_run_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         go_r        <= go_s;
         up_r        <= up_s;
         first_run_r <= enter_run_s;
      end
   end

   // clr_n pulse generator: low from the edge entering CLR for CLR_CYCLES cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_n_r   <= 1'b1;
         clr_cnt_r <= {CLR_W{1'b0}};
      end else if (enter_clr_s) begin
         clr_n_r   <= 1'b0;
         clr_cnt_r <= {CLR_W{1'b0}};
      end else if (state_r == ST_CLR) begin
         if (clr_done_s) begin
            clr_n_r   <= 1'b1;
            clr_cnt_r <= {CLR_W{1'b0}};
         end else begin
            clr_n_r   <= 1'b0;
            clr_cnt_r <= clr_cnt_r + CLR_W'(1);
         end
      end else begin
         clr_n_r   <= 1'b1;
         clr_cnt_r <= {CLR_W{1'b0}};
      end
   end

   // Lap snapshot, taken on the same edge as the RUN->LAP transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lap_r <= {4{DIGIT_BLANK}};
      end else if (lap_en_s) begin
         lap_r <= {bus.cnt3, bus.cnt2, bus.cnt1, bus.cnt0};
      end else begin
         lap_r <= lap_r;
      end
   end

   // Display mux: frozen lap digits in LAP, live counter otherwise.
   always_comb begin
      if (state_r == ST_LAP) begin
         bus.disp0 = lap_r[0];
         bus.disp1 = lap_r[1];
         bus.disp2 = lap_r[2];
         bus.disp3 = lap_r[3];
         bus.disp5 = DIGIT_A;
      end else begin
         bus.disp0 = bus.cnt0;
         bus.disp1 = bus.cnt1;
         bus.disp2 = bus.cnt2;
         bus.disp3 = bus.cnt3;
         if (up_r) begin
            bus.disp5 = DIGIT_ONE;
         end else begin
            bus.disp5 = DIGIT_BLANK;
         end
      end
      bus.disp4 = DIGIT_BLANK;
   end

   assign bus.go    = go_r;
   assign bus.up    = up_r;
   assign bus.clr_n = clr_n_r;
   assign bus.state = state_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Directed bench: stimulus pushes cycle-stamped expectations into a scoreboard
// queue; a monitor on the falling clock edge pops and compares due entries.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

   localparam int F_GO = 0, F_UP = 1, F_CLRN = 2, F_STATE = 3;
   localparam int F_D0 = 4, F_D1 = 5, F_D2 = 6, F_D3 = 7, F_D4 = 8, F_D5 = 9;

   typedef struct {
      int          cyc;
      int          fld;
      logic [31:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic btn_ss, btn_lap, btn_clr, sw_up;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   bit   end_chk = 1'b0;
   exp_t sb_q[$];
   string fname [10] = '{"go", "up", "clr_n", "state", "disp0",
                         "disp1", "disp2", "disp3", "disp4", "disp5"};

   stopwatch_ctrl_if sw_bus ();

   stopwatch_ctrl #(.DB_CYCLES(8), .CLR_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .btn_ss(btn_ss), .btn_lap(btn_lap),
      .btn_clr(btn_clr), .sw_up(sw_up), .bus(sw_bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] get_f(input int f);
      case (f)
         F_GO:    return {31'd0, sw_bus.go};
         F_UP:    return {31'd0, sw_bus.up};
         F_CLRN:  return {31'd0, sw_bus.clr_n};
         F_STATE: return {29'd0, sw_bus.state};
         F_D0:    return {27'd0, sw_bus.disp0};
         F_D1:    return {27'd0, sw_bus.disp1};
         F_D2:    return {27'd0, sw_bus.disp2};
         F_D3:    return {27'd0, sw_bus.disp3};
         F_D4:    return {27'd0, sw_bus.disp4};
         F_D5:    return {27'd0, sw_bus.disp5};
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   // Monitor: compare every expectation due this cycle; flag stale leftovers.
   always @(negedge clk) begin
      logic [31:0] got;
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].cyc <= cyc || end_chk) begin
            got = get_f(sb_q[i].fld);
            n_tests++;
            if (got !== sb_q[i].val || sb_q[i].cyc != cyc) begin
               n_fail++;
               $display("FAIL %s @cyc %0d (due %0d): got %0h expected %0h",
                        fname[sb_q[i].fld], cyc, sb_q[i].cyc, got, sb_q[i].val);
            end
            sb_q.delete(i);
         end
      end
   end

   task automatic expect_at(input int d, input int f, input logic [31:0] v);
      exp_t e;
      e.cyc = cyc + d;
      e.fld = f;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_cnt(input logic [4:0] m, input logic [4:0] s1,
                          input logic [4:0] s0, input logic [4:0] d);
      sw_bus.cnt3 = m;
      sw_bus.cnt2 = s1;
      sw_bus.cnt1 = s0;
      sw_bus.cnt0 = d;
   endtask

   // which: bit0 = ss, bit1 = lap, bit2 = clr; held 12 cycles, then released.
   task automatic press(input logic [2:0] which);
      btn_ss  = which[0];
      btn_lap = which[1];
      btn_clr = which[2];
      step(12);
      btn_ss  = 1'b0;
      btn_lap = 1'b0;
      btn_clr = 1'b0;
      step(12);
   endtask

   initial begin
      rst_n = 1'b0; btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0; sw_up = 1'b1;
      set_cnt(5'h13, 5'h02, 5'h05, 5'h07);
      step(3);
      n_tests++;
      if (sw_bus.state !== 3'd0) begin
         n_fail++;
         $display("FAIL state in reset: got %0h expected 0", sw_bus.state);
      end
      n_tests++;
      if (sw_bus.go !== 1'b0) begin
         n_fail++;
         $display("FAIL go in reset: got %0h expected 0", sw_bus.go);
      end
      n_tests++;
      if (sw_bus.up !== 1'b1) begin
         n_fail++;
         $display("FAIL up in reset: got %0h expected 1", sw_bus.up);
      end
      n_tests++;
      if (sw_bus.clr_n !== 1'b1) begin
         n_fail++;
         $display("FAIL clr_n in reset: got %0h expected 1", sw_bus.clr_n);
      end
      n_tests++;
      if (sw_bus.disp5 !== 5'b0_0001) begin
         n_fail++;
         $display("FAIL disp5 in reset: got %0h expected 1", sw_bus.disp5);
      end
      // Reset values
      expect_at(0, F_STATE, 0); expect_at(0, F_GO, 0); expect_at(0, F_UP, 1);
      expect_at(0, F_CLRN, 1); expect_at(0, F_D5, 1); expect_at(0, F_D4, 0);
      expect_at(0, F_D0, 7);
      rst_n = 1'b1;
      step(20);

      // 1. Glitch of 5 cycles: no pulse
      expect_at(20, F_STATE, 0); expect_at(20, F_GO, 0);
      btn_ss = 1'b1; step(5); btn_ss = 1'b0; step(20);
      // 1. Proper press: go rises 12 cycles after the press begins
      expect_at(11, F_GO, 0); expect_at(12, F_GO, 1); expect_at(12, F_STATE, 1);
      expect_at(12, F_UP, 1);
      press(3'b001);

      // 2. Lap freeze while counter keeps changing
      expect_at(12, F_STATE, 3); expect_at(12, F_D0, 7); expect_at(12, F_D1, 5);
      expect_at(12, F_D2, 2); expect_at(12, F_D3, 5'h13); expect_at(12, F_D5, 5'h0A);
      press(3'b010);
      set_cnt(5'h14, 5'h03, 5'h01, 5'h02);
      expect_at(1, F_D0, 7); expect_at(1, F_D3, 5'h13); expect_at(1, F_GO, 1);
      expect_at(1, F_D4, 0);
      step(2);
      expect_at(12, F_STATE, 1); expect_at(12, F_D0, 2); expect_at(12, F_D3, 5'h14);
      expect_at(12, F_D5, 1);
      press(3'b010);

      // 3. Up limit 9.59.9
      set_cnt(5'h09, 5'h05, 5'h09, 5'h09);
      expect_at(0, F_GO, 1); expect_at(1, F_GO, 0); expect_at(1, F_STATE, 4);
      step(3);
      expect_at(12, F_STATE, 4); expect_at(12, F_UP, 1); expect_at(12, F_GO, 0);
      press(3'b001);
      expect_at(11, F_CLRN, 1); expect_at(12, F_CLRN, 0); expect_at(12, F_STATE, 5);
      expect_at(13, F_GO, 0); expect_at(15, F_CLRN, 0); expect_at(15, F_STATE, 5);
      expect_at(16, F_CLRN, 1); expect_at(16, F_STATE, 0);
      press(3'b100);

      // 4. Down direction from PAUSE, then lower limit
      set_cnt(5'h01, 5'h00, 5'h00, 5'h00);
      expect_at(12, F_STATE, 1);
      press(3'b001);
      expect_at(12, F_STATE, 2); expect_at(12, F_GO, 0);
      press(3'b001);
      sw_up = 1'b0;
      expect_at(10, F_UP, 1); expect_at(11, F_UP, 0); expect_at(11, F_D5, 0);
      step(14);
      expect_at(12, F_UP, 0); expect_at(12, F_GO, 1); expect_at(12, F_STATE, 1);
      press(3'b001);
      set_cnt(5'h00, 5'h00, 5'h00, 5'h00);
      expect_at(0, F_STATE, 1); expect_at(1, F_STATE, 4); expect_at(1, F_GO, 0);
      step(3);

      // 5. Back to up counting, then simultaneous ss+lap in RUN
      set_cnt(5'h13, 5'h02, 5'h05, 5'h07);
      sw_up = 1'b1;
      expect_at(16, F_STATE, 0); expect_at(20, F_UP, 1);
      press(3'b100);
      expect_at(12, F_STATE, 1);
      press(3'b001);
      expect_at(12, F_STATE, 2); expect_at(12, F_D5, 1); expect_at(12, F_D0, 7);
      press(3'b011);
      expect_at(12, F_STATE, 1);
      press(3'b001);
      // clr in RUN is ignored
      expect_at(12, F_STATE, 1); expect_at(12, F_CLRN, 1); expect_at(14, F_CLRN, 1);
      press(3'b100);

      // 6. Reset in the middle of the clr_n pulse
      expect_at(12, F_STATE, 2);
      press(3'b001);
      expect_at(12, F_CLRN, 0); expect_at(12, F_STATE, 5);
      btn_clr = 1'b1;
      step(13);
      rst_n = 1'b0;
      expect_at(0, F_CLRN, 1); expect_at(0, F_STATE, 0); expect_at(0, F_UP, 1);
      expect_at(0, F_D5, 1); expect_at(0, F_GO, 0);
      step(2);
      btn_clr = 1'b0;
      rst_n = 1'b1;
      expect_at(15, F_STATE, 0); expect_at(15, F_CLRN, 1);
      step(20);

      end_chk = 1'b1;
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Watchdog: the directed sequence is a few hundred cycles long.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
